clock_mode_ctrl: RTL and testbench
==================================

Name: clock_mode_ctrl

Overview:
- Mode sequencer for the six-digit clock / alarm / stopwatch board design.
- Turns two push-buttons and a 1 Hz tick into:
  - the current mode and display-source select,
  - one-cycle increment strobes to the timekeeper,
  - ownership of the alarm-time registers,
  - stopwatch run/clear controls,
  - edit-field blink masking and alarm ringing.
- Sits between the board inputs and the timekeeper / stopwatch / HEX-decoder datapath.

Parameters:
- BLINK_DIV, 25000000, clk cycles per blink half-period.
- AUTO_EXIT_SECS, 30, seconds without a press before an edit mode returns to S_CLOCK.
- RING_SECS, 60, seconds the alarm rings before self-cancelling.
- SNOOZE_SECS, 300, snooze length; used only with CLOCK_SNOOZE_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn_mode  in  1  mode button level, already synchronised
- btn_adj  in  1  adjust button level, already synchronised
- tick_1s  in  1  one-cycle pulse per second from the timekeeper
- cur_hour  in  5  timekeeper hours, 0..23
- cur_min  in  6  timekeeper minutes, 0..59
- cur_sec  in  6  timekeeper seconds, 0..59
- alarm_en  in  1  alarm arm switch
- mode  out  3  state encoding, see Behaviour
- disp_sel  out  2  display source: 0 time, 1 alarm, 2 stopwatch
- inc_hour  out  1  one-cycle hour-increment strobe
- inc_min  out  1  one-cycle minute-increment strobe
- inc_sec  out  1  one-cycle second-increment strobe
- alarm_hour  out  5  alarm hour, 0..23
- alarm_min  out  6  alarm minute, 0..59
- chrono_run  out  1  stopwatch running
- chrono_clr  out  1  one-cycle stopwatch clear
- blink_mask  out  6  1 = blank digit; bit0 = rightmost digit
- ring  out  1  alarm sounding

Behaviour:
- Reset: all outputs 0 (mode=S_CLOCK, alarm 00:00, ring 0). Internal counters and button history are also cleared. Reset mid-edit, mid-ring or mid-run abandons the activity with no strobes.
- Press detection: press = btn & ~btn_q. All outputs are registered: an action is visible the cycle after the first edge at which btn is sampled high. Strobes last exactly one cycle; holding a button gives one press.
- States and mode encoding: S_CLOCK=0, S_SET_HOUR=1, S_SET_MIN=2, S_SET_SEC=3, S_ALM_HOUR=4, S_ALM_MIN=5, S_CHRONO=6.
- Mode press advances 0→1→…→6→0.
- disp_sel by state:
  - 1 in S_ALM_HOUR and S_ALM_MIN,
  - 2 in S_CHRONO,
  - else 0.
- Adjust press by state:
  - S_SET_HOUR / S_SET_MIN / S_SET_SEC: pulse inc_hour / inc_min / inc_sec respectively.
  - S_ALM_HOUR: alarm_hour increments, 23→0.
  - S_ALM_MIN: alarm_min increments, 59→0.
  - S_CHRONO: toggles chrono_run.
  - S_CLOCK: no effect.
- Simultaneous mode+adj press:
  - in S_CHRONO: chrono_clr=1 for one cycle, chrono_run←0, state unchanged;
  - elsewhere: mode press wins and adj is ignored.
- Stopwatch independence: chrono_run keeps its value when leaving S_CHRONO, so the stopwatch runs in the background.
- Auto-exit: in states 1..5, an idle counter counts tick_1s and clears on any press. At AUTO_EXIT_SECS it forces S_CLOCK. A tick and a press in the same cycle: the press wins (counter cleared).
- Blink: a free-running counter toggles blink_phase every BLINK_DIV cycles. When phase=1, blink_mask by state:
  - SET_HOUR / ALM_HOUR: 110000
  - SET_MIN / ALM_MIN: 001100
  - SET_SEC: 000011
  - all other states: 000000
- Alarm match: match = alarm_en & (cur_hour==alarm_hour) & (cur_min==alarm_min) & (cur_sec==0).
- Ring start: the rising edge of match sets ring, but not in states 4/5.
- Ring stop: ring clears after RING_SECS ticks, on any press, or immediately when alarm_en=0.
- A cancelling press is consumed: no mode change, no strobe.

Optional Feature:
- Macro: CLOCK_SNOOZE_EN.
- Defined:
  - adj press while ring=1 clears ring and loads a snooze counter with SNOOZE_SECS;
  - when that counter expires, ring re-asserts once, independent of match;
  - mode press cancels both ring and snooze;
  - alarm_en=0 also cancels both.
- Undefined: no snooze logic; any press cancels ring.

Decomposition:
- Package clock_ctrl_pkg holds:
  - the mode state enum,
  - DISP_TIME / DISP_ALARM / DISP_CHRONO,
  - MASK_HOUR / MASK_MIN / MASK_SEC constants.
- One sub-module, edge_pulse: registers a level and outputs a one-cycle rising-edge pulse. It is instantiated twice.

Test Plan:
- Reset, then press mode 7 times → mode 1,2,3,4,5,6,0 and disp_sel 0,0,0,1,1,2,0.
- In S_ALM_HOUR, 25 adj presses from 00 → alarm_hour=1 (wraps at 24). In S_ALM_MIN, 61 presses → alarm_min=1. Inputs held across many cycles produce single increments only.
- Alarm 07:30, alarm_en=1, drive cur time 07:29:59→07:30:00 → ring=1. After 60 ticks ring=0. Repeat with an adj press at tick 5 → ring=0, mode stays 0, no inc strobe.
- In S_CHRONO: adj → chrono_run=1; leave to S_CLOCK → chrono_run stays 1; return and press both → chrono_clr pulse, chrono_run=0, mode=6.
- In S_SET_MIN, idle 30 ticks → mode=0. Repeat with a press at tick 29 → still mode 2 at tick 58. With BLINK_DIV=4, blink_mask alternates 001100/000000 every 4 cycles.
- With CLOCK_SNOOZE_EN and SNOOZE_SECS=3: during ring, adj → ring=0; 3 ticks later ring=1. Mode press → ring=0 and no re-ring.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - state encoding, display-source and blink-mask constants for clock_mode_ctrl
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        S_CLOCK    = 3'd0,
        S_SET_HOUR = 3'd1,
        S_SET_MIN  = 3'd2,
        S_SET_SEC  = 3'd3,
        S_ALM_HOUR = 3'd4,
        S_ALM_MIN  = 3'd5,
        S_CHRONO   = 3'd6
    } mode_t;

    localparam logic [1:0] DISP_TIME   = 2'd0;
    localparam logic [1:0] DISP_ALARM  = 2'd1;
    localparam logic [1:0] DISP_CHRONO = 2'd2;

    localparam logic [5:0] MASK_HOUR = 6'b110000;
    localparam logic [5:0] MASK_MIN  = 6'b001100;
    localparam logic [5:0] MASK_SEC  = 6'b000011;

    function automatic logic [1:0] disp_for(input mode_t s);
        case (s)
            S_ALM_HOUR, S_ALM_MIN: disp_for = DISP_ALARM;
            S_CHRONO:              disp_for = DISP_CHRONO;
            default:               disp_for = DISP_TIME;
        endcase
    endfunction

    function automatic logic [5:0] mask_for(input mode_t s);
        case (s)
            S_SET_HOUR, S_ALM_HOUR: mask_for = MASK_HOUR;
            S_SET_MIN, S_ALM_MIN:   mask_for = MASK_MIN;
            S_SET_SEC:              mask_for = MASK_SEC;
            default:                mask_for = 6'd0;
        endcase
    endfunction

    function automatic mode_t next_mode(input mode_t s);
        next_mode = (s == S_CHRONO) ? S_CLOCK : mode_t'(s + 3'd1);
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - level history register with a one-cycle rising-edge pulse
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level;
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - mode sequencer for the clock/alarm/stopwatch board
// Optional CLOCK_SNOOZE_EN: adjust press while ringing snoozes for SNOOZE_SECS.
module clock_mode_ctrl #(
    parameter int BLINK_DIV      = 25000000,
    parameter int AUTO_EXIT_SECS = 30,
    parameter int RING_SECS      = 60,
    parameter int SNOOZE_SECS    = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_adj,
    input  logic       tick_1s,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       alarm_en,
    output logic [2:0] mode,
    output logic [1:0] disp_sel,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_sec,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       chrono_run,
    output logic       chrono_clr,
    output logic [5:0] blink_mask,
    output logic       ring
);
    import clock_ctrl_pkg::*;

    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int IW = $clog2(AUTO_EXIT_SECS + 1);
    localparam int RW = $clog2(RING_SECS + 1);

    mode_t         state, state_nxt;
    logic          mode_p, adj_p, any_press, consumed, act_mode, act_adj;
    logic          chrono_both, in_edit, idle_exit;
    logic          match, match_q, ring_start, ring_expire, snooze_fire;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase, blink_wrap, phase_nxt;
    logic [IW-1:0] idle_cnt;
    logic [RW-1:0] ring_cnt;

    edge_pulse u_mode_edge (.clk(clk), .rst(rst), .level(btn_mode), .pulse(mode_p));
    edge_pulse u_adj_edge  (.clk(clk), .rst(rst), .level(btn_adj),  .pulse(adj_p));

    // A press that silences the alarm does nothing else.
    assign any_press   = mode_p | adj_p;
    assign consumed    = ring & any_press;
    assign act_mode    = mode_p & ~consumed;
    assign act_adj     = adj_p & ~consumed;
    assign chrono_both = act_mode & act_adj & (state == S_CHRONO);
    assign in_edit     = (state != S_CLOCK) && (state != S_CHRONO);
    assign idle_exit   = in_edit & tick_1s & ~any_press & (idle_cnt == IW'(AUTO_EXIT_SECS - 1));

    assign match       = alarm_en & (cur_hour == alarm_hour) & (cur_min == alarm_min) & (cur_sec == 6'd0);
    assign ring_start  = match & ~match_q & (state != S_ALM_HOUR) & (state != S_ALM_MIN);
    assign ring_expire = ring & tick_1s & (ring_cnt == RW'(RING_SECS - 1));

    assign blink_wrap  = (blink_cnt == BW'(BLINK_DIV - 1));
    assign phase_nxt   = blink_phase ^ blink_wrap;
    assign mode        = state;

`ifdef CLOCK_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_SECS + 1);
    logic          snooze_act;
    logic [SW-1:0] snooze_cnt;
    assign snooze_fire = snooze_act & tick_1s & ~mode_p & (snooze_cnt == SW'(SNOOZE_SECS - 1));
`else
    logic unused_snooze;
    assign unused_snooze = ^SNOOZE_SECS;
    assign snooze_fire   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (act_mode && !chrono_both) state_nxt = next_mode(state);
        else if (idle_exit)           state_nxt = S_CLOCK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_CLOCK;
            disp_sel    <= DISP_TIME;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            blink_mask  <= 6'd0;
            inc_hour    <= 1'b0;
            inc_min     <= 1'b0;
            inc_sec     <= 1'b0;
            chrono_clr  <= 1'b0;
            chrono_run  <= 1'b0;
            alarm_hour  <= 5'd0;
            alarm_min   <= 6'd0;
            idle_cnt    <= '0;
            match_q     <= 1'b0;
            ring        <= 1'b0;
            ring_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            disp_sel    <= disp_for(state_nxt);
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
            blink_phase <= phase_nxt;
            blink_mask  <= phase_nxt ? mask_for(state_nxt) : 6'd0;
            inc_hour    <= 1'b0;
            inc_min     <= 1'b0;
            inc_sec     <= 1'b0;
            chrono_clr  <= 1'b0;
            match_q     <= match;

            if (!in_edit || any_press || idle_exit) idle_cnt <= '0;
            else if (tick_1s)                       idle_cnt <= idle_cnt + 1'b1;

            if (chrono_both) begin
                chrono_clr <= 1'b1;
                chrono_run <= 1'b0;
            end else if (act_adj && !act_mode) begin
                case (state)
                    S_SET_HOUR: inc_hour   <= 1'b1;
                    S_SET_MIN:  inc_min    <= 1'b1;
                    S_SET_SEC:  inc_sec    <= 1'b1;
                    S_ALM_HOUR: alarm_hour <= (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
                    S_ALM_MIN:  alarm_min  <= (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
                    S_CHRONO:   chrono_run <= ~chrono_run;
                    default: ;
                endcase
            end

            if (ring && tick_1s) ring_cnt <= ring_cnt + 1'b1;
            if (!alarm_en || consumed || ring_expire) begin
                ring <= 1'b0;
            end else if (ring_start || snooze_fire) begin
                ring     <= 1'b1;
                ring_cnt <= '0;
            end
        end
    end

`ifdef CLOCK_SNOOZE_EN
    always_ff @(posedge clk) begin
        if (rst || !alarm_en || mode_p) begin
            snooze_act <= 1'b0;
            snooze_cnt <= '0;
        end else if (ring && adj_p) begin
            snooze_act <= 1'b1;
            snooze_cnt <= '0;
        end else if (snooze_fire) begin
            snooze_act <= 1'b0;
        end else if (snooze_act && tick_1s) begin
            snooze_cnt <= snooze_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - self-checking bench for clock_mode_ctrl
module tb_clock_mode_ctrl;
    import clock_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_adj, tick_1s, alarm_en;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [2:0] mode;
    logic [1:0] disp_sel;
    logic       inc_hour, inc_min, inc_sec, chrono_run, chrono_clr, ring;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [5:0] blink_mask;

    int checks = 0;
    int errors = 0;
    logic [3:0] strobe_q[$];
    logic [4:0] md_q[$];
    logic [3:0] obs_s, exp_s;

    clock_mode_ctrl #(.BLINK_DIV(4), .AUTO_EXIT_SECS(30), .RING_SECS(60), .SNOOZE_SECS(3)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_adj(btn_adj), .tick_1s(tick_1s),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec), .alarm_en(alarm_en),
        .mode(mode), .disp_sel(disp_sel), .inc_hour(inc_hour), .inc_min(inc_min), .inc_sec(inc_sec),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .chrono_run(chrono_run),
        .chrono_clr(chrono_clr), .blink_mask(blink_mask), .ring(ring)
    );

    always #5 clk = ~clk;

    // Every strobe seen must match the oldest outstanding expectation.
    always @(negedge clk) begin
        obs_s = {inc_hour, inc_min, inc_sec, chrono_clr};
        if (!rst && obs_s != 4'd0) begin
            checks++;
            if (strobe_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got %b, required none", obs_s);
            end else begin
                exp_s = strobe_q.pop_front();
                if (obs_s !== exp_s) begin
                    errors++;
                    $display("FAIL strobe: got %b, required %b", obs_s, exp_s);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic a);
        btn_mode = m; btn_adj = a;
        step(1);
        btn_mode = 1'b0; btn_adj = 1'b0;
        step(1);
    endtask

    task automatic press_adj_hold(input int n);
        btn_adj = 1'b1;
        step(n);
        btn_adj = 1'b0;
        step(1);
    endtask

    task automatic tick1();
        tick_1s = 1'b1;
        step(1);
        tick_1s = 1'b0;
        step(1);
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hour = h; cur_min = m; cur_sec = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_mode = 1'b0; btn_adj = 1'b0; tick_1s = 1'b0; alarm_en = 1'b0;
        set_time(5'd12, 6'd0, 6'd0);
        step(3);
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL reset_mode: got %0d, required 0", mode); end
        checks++; if (disp_sel !== 2'd0) begin errors++; $display("FAIL reset_disp: got %0d, required 0", disp_sel); end
        checks++; if ({alarm_hour, alarm_min} !== 11'd0) begin errors++; $display("FAIL reset_alarm: got %0d:%0d, required 0:0", alarm_hour, alarm_min); end
        checks++; if ({ring, chrono_run, blink_mask} !== 8'd0) begin errors++; $display("FAIL reset_misc: got ring=%b run=%b mask=%b, required 0", ring, chrono_run, blink_mask); end
        checks++; if ({inc_hour, inc_min, inc_sec, chrono_clr} !== 4'd0) begin errors++; $display("FAIL reset_strobes: got %b, required 0000", {inc_hour, inc_min, inc_sec, chrono_clr}); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_mode_cycle();
        logic [2:0] m;
        logic [4:0] e;
        for (int i = 1; i <= 7; i++) begin
            m = 3'(i % 7);
            md_q.push_back({m, (m == 3'd4 || m == 3'd5) ? 2'd1 : (m == 3'd6) ? 2'd2 : 2'd0});
            press(1'b1, 1'b0);
            e = md_q.pop_front();
            checks++;
            if ({mode, disp_sel} !== e) begin
                errors++;
                $display("FAIL mode_cycle: got mode=%0d disp=%0d, required mode=%0d disp=%0d", mode, disp_sel, e[4:2], e[1:0]);
            end
        end
    endtask

    task automatic test_set_strobes();
        press(1'b0, 1'b1);
        press(1'b1, 1'b0); strobe_q.push_back(4'b1000); press(1'b0, 1'b1);
        press(1'b1, 1'b0); strobe_q.push_back(4'b0100); press(1'b0, 1'b1);
        press(1'b1, 1'b0); strobe_q.push_back(4'b0010); press_adj_hold(6);
        checks++; if (strobe_q.size() != 0) begin errors++; $display("FAIL set_strobes_missing: got %0d outstanding, required 0", strobe_q.size()); end
        checks++; if (mode !== 3'd3) begin errors++; $display("FAIL set_strobes_mode: got %0d, required 3", mode); end
    endtask

    task automatic test_alarm_set();
        int h, m;
        h = 0; m = 0;
        press(1'b1, 1'b0);
        checks++; if (mode !== 3'd4) begin errors++; $display("FAIL alarm_mode: got %0d, required 4", mode); end
        for (int i = 0; i < 31; i++) begin
            press_adj_hold(3);
            h = (h + 1) % 24;
            checks++; if (alarm_hour !== 5'(h)) begin errors++; $display("FAIL alarm_hour step %0d: got %0d, required %0d", i, alarm_hour, h); end
        end
        press(1'b1, 1'b0);
        for (int i = 0; i < 90; i++) begin
            press_adj_hold(3);
            m = (m + 1) % 60;
            checks++; if (alarm_min !== 6'(m)) begin errors++; $display("FAIL alarm_min step %0d: got %0d, required %0d", i, alarm_min, m); end
        end
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL alarm_return: got %0d, required 0", mode); end
    endtask

    task automatic test_ring();
        alarm_en = 1'b1;
        set_time(5'd7, 6'd29, 6'd59);
        step(2);
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL ring_early: got %b, required 0", ring); end
        set_time(5'd7, 6'd30, 6'd0);
        tick1();
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_start: got %b, required 1", ring); end
        for (int t = 1; t <= 60; t++) begin
            set_time(5'd7, 6'(30 + t / 60), 6'(t % 60));
            tick1();
            checks++; if (ring !== (t < 60)) begin errors++; $display("FAIL ring_hold tick %0d: got %b, required %b", t, ring, t < 60); end
        end

        set_time(5'd7, 6'd29, 6'd59); step(1);
        set_time(5'd7, 6'd30, 6'd0);  step(1);
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_restart: got %b, required 1", ring); end
        press(1'b1, 1'b0);
        checks++; if ({ring, mode} !== 4'd0) begin errors++; $display("FAIL ring_mode_cancel: got ring=%b mode=%0d, required 0/0", ring, mode); end

        set_time(5'd7, 6'd29, 6'd59); step(1);
        set_time(5'd7, 6'd30, 6'd0);  step(1);
        alarm_en = 1'b0;
        step(1);
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL ring_disable: got %b, required 0", ring); end
        set_time(5'd7, 6'd31, 6'd0);
        alarm_en = 1'b1;

        set_time(5'd7, 6'd29, 6'd59); step(1);
        set_time(5'd7, 6'd30, 6'd0);  step(1);
        for (int t = 1; t <= 5; t++) begin
            set_time(5'd7, 6'd30, 6'(t));
            tick1();
        end
        checks++; if (ring !== 1'b1) begin errors++; $display("FAIL ring_tick5: got %b, required 1", ring); end
        press(1'b0, 1'b1);
        checks++; if ({ring, mode} !== 4'd0) begin errors++; $display("FAIL ring_adj_cancel: got ring=%b mode=%0d, required 0/0", ring, mode); end
`ifdef CLOCK_SNOOZE_EN
        for (int t = 1; t <= 3; t++) begin
            tick1();
            checks++; if (ring !== (t == 3)) begin errors++; $display("FAIL snooze tick %0d: got %b, required %b", t, ring, t == 3); end
        end
        press(1'b1, 1'b0);
        checks++; if ({ring, mode} !== 4'd0) begin errors++; $display("FAIL snooze_mode_cancel: got ring=%b mode=%0d, required 0/0", ring, mode); end
        for (int t = 0; t < 5; t++) tick1();
        checks++; if (ring !== 1'b0) begin errors++; $display("FAIL snooze_rering: got %b, required 0", ring); end
`endif
        alarm_en = 1'b0;
        step(1);
    endtask

    task automatic test_chrono();
        repeat (6) press(1'b1, 1'b0);
        checks++; if ({mode, disp_sel} !== {3'd6, 2'd2}) begin errors++; $display("FAIL chrono_enter: got mode=%0d disp=%0d, required 6/2", mode, disp_sel); end
        press(1'b0, 1'b1);
        checks++; if (chrono_run !== 1'b1) begin errors++; $display("FAIL chrono_start: got %b, required 1", chrono_run); end
        press(1'b1, 1'b0);
        checks++; if ({mode, chrono_run} !== 4'b0001) begin errors++; $display("FAIL chrono_background: got mode=%0d run=%b, required 0/1", mode, chrono_run); end
        repeat (6) press(1'b1, 1'b0);
        strobe_q.push_back(4'b0001);
        press(1'b1, 1'b1);
        checks++; if ({mode, chrono_run} !== 4'b1100) begin errors++; $display("FAIL chrono_clear: got mode=%0d run=%b, required 6/0", mode, chrono_run); end
        press(1'b1, 1'b0);
    endtask

    task automatic test_auto_exit();
        logic [5:0] s[24];
        int trans;
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL exit_enter: got %0d, required 2", mode); end
        for (int i = 0; i < 24; i++) begin s[i] = blink_mask; step(1); end
        trans = 0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0 && s[i] != s[i-1]) trans++;
            if (i < 20) begin
                checks++;
                if ((s[i] !== MASK_MIN && s[i] !== 6'd0) || s[i+4] !== ((s[i] == MASK_MIN) ? 6'd0 : MASK_MIN)) begin
                    errors++; $display("FAIL blink cycle %0d: got %b then %b", i, s[i], s[i+4]);
                end
            end
        end
        checks++; if (trans < 5 || trans > 6) begin errors++; $display("FAIL blink_rate: got %0d toggles, required 5 or 6", trans); end
        for (int t = 1; t <= 30; t++) begin
            tick1();
            if (t >= 29) begin
                checks++; if (mode !== ((t == 30) ? 3'd0 : 3'd2)) begin errors++; $display("FAIL auto_exit tick %0d: got %0d", t, mode); end
            end
        end
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        for (int t = 1; t <= 29; t++) tick1();
        strobe_q.push_back(4'b0100);
        press(1'b0, 1'b1);
        for (int t = 30; t <= 58; t++) tick1();
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL exit_press_hold: got %0d, required 2", mode); end
        tick1();
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL exit_press_expire: got %0d, required 0", mode); end
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_set_strobes();
        test_alarm_set();
        test_ring();
        test_chrono();
        test_auto_exit();
        step(2);
        checks++; if (strobe_q.size() != 0) begin errors++; $display("FAIL strobe_missing: got %0d outstanding, required 0", strobe_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
